// File: rtl/usb_tx_engine_p.sv
// usb_tx_engine_p: USB packet transmitter (SYNC, PID, payload, CRC16, EOP).
// Optional low-speed mode is compiled in with `define USB_TX_LOWSPEED_EN.
module usb_tx_engine_p #(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              transmit_empty,
  input  logic              transmit_start,
  input  logic [3:0]        pid,
`ifdef USB_TX_LOWSPEED_EN
  input  logic              low_speed,
`endif
  output logic              read_enable,
  output logic              d_plus_out,
  output logic              d_minus_out,
  output logic              busy,
  output logic              tx_error
);
  localparam int NB = DATA_W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(CLKS_PER_BIT * 8);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP
  } st_t;

  st_t               st, st_nx;
  logic [TW-1:0]     timer, bt_last;
  logic [3:0]        bcnt, pid_r;
  logic [IW-1:0]     bidx;
  logic [BW-1:0]     bsent;
  logic [2:0]        ones;
  logic [15:0]       crc, crc_nx;
  logic [DATA_W-1:0] sh;
  logic              lvl, se0, lvl_nx, se0_nx, inv_nx;
  logic              strobe, stuff, adv, raw_nx, pop, lim;
  logic              byte_end, last_byte, cap, is_data, fb;

`ifdef USB_TX_LOWSPEED_EN
  logic ls;

  // speed mode is latched per packet; idle polarity follows it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ls <= 1'b0;
    else if (st == S_IDLE && transmit_start) ls <= low_speed;
  end

  assign bt_last = ls ? TW'(CLKS_PER_BIT * 8 - 1)
                      : TW'(CLKS_PER_BIT - 1);
  assign inv_nx  = (st == S_IDLE && transmit_start) ? low_speed : ls;
`else
  assign bt_last = TW'(CLKS_PER_BIT - 1);
  assign inv_nx  = 1'b0;
`endif

  assign strobe      = busy && (timer == bt_last);
  assign stuff       = (ones == 3'd6);
  assign adv         = strobe && !stuff;
  assign byte_end    = (bcnt == 4'd7);
  assign last_byte   = (bidx == IW'(NB - 1));
  assign cap         = (bsent >= BW'(MAX_BYTES - 1));
  assign is_data     = (pid_r[1:0] == 2'b11);
  assign read_enable = pop;
  assign fb          = crc[15] ^ raw_nx;
  assign crc_nx      = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);

  // next raw bit, next field and FIFO pop decision at each bit strobe
  always_comb begin
    st_nx  = st;
    raw_nx = 1'b0;
    pop    = 1'b0;
    lim    = 1'b0;
    if (adv) begin
      unique case (st)
        S_SYNC: begin
          if (!byte_end) raw_nx = sh[1];
          else begin
            st_nx  = S_PID;
            raw_nx = pid_r[0];
          end
        end
        S_PID: begin
          if (!byte_end) raw_nx = sh[1];
          else if (!is_data) st_nx = S_EOP;
          else if (!transmit_empty) begin
            st_nx  = S_DATA;
            pop    = 1'b1;
            raw_nx = tx_data[0];
          end else begin
            st_nx  = S_CRC;
            raw_nx = ~crc[15];
          end
        end
        S_DATA: begin
          if (!byte_end) raw_nx = sh[1];
          else if (cap) begin
            st_nx  = S_CRC;
            raw_nx = ~crc[15];
            lim    = !last_byte || !transmit_empty;
          end else if (!last_byte) raw_nx = sh[1];
          else if (!transmit_empty) begin
            pop    = 1'b1;
            raw_nx = tx_data[0];
          end else begin
            st_nx  = S_CRC;
            raw_nx = ~crc[15];
          end
        end
        S_CRC: begin
          if (bcnt == 4'd15) st_nx = S_EOP;
          else raw_nx = ~crc[14];
        end
        S_EOP: begin
          if (bcnt == 4'd2) st_nx = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // NRZI line level (1 = J) and SE0 for the next bit time
  always_comb begin
    lvl_nx = lvl;
    se0_nx = se0;
    if (st == S_IDLE) begin
      if (transmit_start) begin
        lvl_nx = 1'b0;
        se0_nx = 1'b0;
      end
    end else if (strobe && stuff) begin
      lvl_nx = ~lvl;
    end else if (adv) begin
      if (st_nx == S_EOP) begin
        se0_nx = (st != S_EOP) || (bcnt == 4'd0);
        lvl_nx = 1'b1;
      end else if (st_nx == S_IDLE) begin
        se0_nx = 1'b0;
        lvl_nx = 1'b1;
      end else begin
        lvl_nx = raw_nx ? lvl : ~lvl;
      end
    end
  end

  // packet FSM, bit timer, shifter, CRC, stuffing counter and pads
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st          <= S_IDLE;
      busy        <= 1'b0;
      tx_error    <= 1'b0;
      timer       <= '0;
      bcnt        <= '0;
      pid_r       <= '0;
      bidx        <= '0;
      bsent       <= '0;
      ones        <= '0;
      crc         <= 16'hFFFF;
      sh          <= '0;
      lvl         <= 1'b1;
      se0         <= 1'b0;
      d_plus_out  <= 1'b1;
      d_minus_out <= 1'b0;
    end else begin
      lvl         <= lvl_nx;
      se0         <= se0_nx;
      d_plus_out  <= ~se0_nx & (lvl_nx ^ inv_nx);
      d_minus_out <= ~se0_nx & ~(lvl_nx ^ inv_nx);
      if (st == S_IDLE) begin
        timer <= '0;
        if (transmit_start) begin
          st       <= S_SYNC;
          busy     <= 1'b1;
          tx_error <= 1'b0;
          pid_r    <= pid;
          sh       <= DATA_W'(8'h80);
          bcnt     <= '0;
          bidx     <= '0;
          bsent    <= '0;
          ones     <= '0;
          crc      <= 16'hFFFF;
        end
      end else begin
        if (transmit_start || lim) tx_error <= 1'b1;
        timer <= strobe ? '0 : timer + 1'b1;
        if (strobe && stuff) begin
          ones <= '0;
        end else if (adv) begin
          st   <= st_nx;
          busy <= (st_nx != S_IDLE);
          if (st_nx == S_EOP || st_nx == S_IDLE) ones <= '0;
          else ones <= raw_nx ? ones + 3'd1 : 3'd0;
          if (st_nx != st || (st == S_DATA && byte_end)) bcnt <= '0;
          else bcnt <= bcnt + 4'd1;
          if (pop) sh <= tx_data;
          else if (st == S_SYNC && byte_end) sh <= DATA_W'({~pid_r, pid_r});
          else sh <= sh >> 1;
          if (st_nx == S_DATA) crc <= crc_nx;
          else if (st == S_CRC) crc <= crc << 1;
          if (st == S_DATA && byte_end) begin
            bsent <= bsent + 1'b1;
            bidx  <= pop ? '0 : bidx + 1'b1;
          end else if (pop) begin
            bidx <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_engine_p.sv
// tb_usb_tx_engine_p: directed vectors against a bit-level line model.
// Configuration: DATA_W=16, CLKS_PER_BIT=8, MAX_BYTES=4.
module tb_usb_tx_engine_p;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

  logic        clk, n_rst;
  logic [15:0] tx_data;
  logic        transmit_empty, transmit_start;
  logic [3:0]  pid;
  logic        read_enable, d_plus_out, d_minus_out, busy, tx_error;

  usb_tx_engine_p #(
    .DATA_W(16), .CLKS_PER_BIT(8), .MAX_BYTES(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data),
    .transmit_empty(transmit_empty), .transmit_start(transmit_start),
    .pid(pid), .read_enable(read_enable),
    .d_plus_out(d_plus_out), .d_minus_out(d_minus_out),
    .busy(busy), .tx_error(tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] fifo [8];
  logic [3:0]  rd = '0, wr = '0;
  int          npop = 0, bad_re = 0;
  assign tx_data        = fifo[rd[2:0]];
  assign transmit_empty = (rd == wr);

  always @(posedge clk)
    if (read_enable) begin
      rd   <= rd + 4'd1;
      npop <= npop + 1;
      if (transmit_empty) bad_re <= bad_re + 1;
    end

  typedef struct {
    logic [3:0]  pid;
    int          nw;
    logic [15:0] w0, w1, w2;
    int          pops;
    bit          err;
    int          left;
    int          dbl;
  } vec_t;

  vec_t        vt [8];
  int          checks = 0, errors = 0;
  logic [7:0]  pay [$];
  logic [1:0]  esym [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fifo[wr[2:0]] = w;
    wr = wr + 4'd1;
  endtask

  // expected line symbols: stuffing over SYNC..CRC, NRZI from J, then EOP
  task automatic build(input logic [3:0] p, input bit dat);
    bit          raw [$];
    logic [7:0]  pb;
    logic [15:0] c;
    int          ones;
    bit          lv, b;
    raw  = {};
    esym = {};
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    pb = {~p, p};
    for (int i = 0; i < 8; i++) raw.push_back(pb[i]);
    if (dat) begin
      c = 16'hFFFF;
      foreach (pay[j])
        for (int i = 0; i < 8; i++) begin
          b = pay[j][i];
          raw.push_back(b);
          c = (c[0] ^ b) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
      for (int i = 0; i < 16; i++) raw.push_back(~c[i]);
    end
    lv   = 1'b1;
    ones = 0;
    foreach (raw[i]) begin
      if (!raw[i]) lv = ~lv;
      esym.push_back(lv ? J : K);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lv = ~lv;
        esym.push_back(lv ? J : K);
        ones = 0;
      end
    end
    esym.push_back(SE0);
    esym.push_back(SE0);
    esym.push_back(J);
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          n, p0, bad;
    logic [1:0]  s, bads;
    logic [15:0] ws [3];
    string       tag;
    v     = vt[i];
    tag   = $sformatf("v%0d", i);
    ws[0] = v.w0;
    ws[1] = v.w1;
    ws[2] = v.w2;
    wr    = rd;
    for (int j = 0; j < v.nw; j++) push(ws[j]);
    pay = {};
    for (int j = 0; j < v.pops; j++) begin
      pay.push_back(ws[j][7:0]);
      pay.push_back(ws[j][15:8]);
    end
    build(v.pid, v.pid[1:0] == 2'b11);
    n    = esym.size();
    p0   = npop;
    bad  = -1;
    bads = 2'b00;
    @(negedge clk);
    pid            = v.pid;
    transmit_start = 1'b1;
    @(negedge clk);
    transmit_start = 1'b0;
    chk({tag, "_err_clr"}, 32'(tx_error), 32'(0));
    chk({tag, "_first_k"}, 32'({d_plus_out, d_minus_out}), 32'(K));
    repeat (3) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      s = {d_plus_out, d_minus_out};
      if (s !== esym[k] && bad < 0) begin
        bad  = k;
        bads = s;
      end
      if (k < n - 1) begin
        if (k == v.dbl) begin
          transmit_start = 1'b1;
          @(negedge clk);
          transmit_start = 1'b0;
          repeat (7) @(negedge clk);
        end else begin
          repeat (8) @(negedge clk);
        end
      end
    end
    if (bad >= 0)
      chk({tag, "_lines"}, 32'({bad[15:0], 14'd0, bads}),
          32'({bad[15:0], 14'd0, esym[bad]}));
    else
      chk({tag, "_lines"}, 32'(bad), 32'(-1));
    repeat (4) @(negedge clk);
    chk({tag, "_busy_last"}, 32'(busy), 32'(1));
    @(negedge clk);
    chk({tag, "_busy_end"}, 32'(busy), 32'(0));
    chk({tag, "_pops"}, 32'(npop - p0), 32'(v.pops));
    chk({tag, "_tx_error"}, 32'(tx_error), 32'(v.err));
    chk({tag, "_left"}, 32'(wr - rd), 32'(v.left));
  endtask

  initial begin
    n_rst          = 1'b1;
    transmit_start = 1'b0;
    pid            = 4'h0;
    for (int i = 0; i < 8; i++) fifo[i] = 16'h0000;
    #2 n_rst = 1'b0;
    #1;
    chk("rst_lines", 32'({d_plus_out, d_minus_out}), 32'(J));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_re", 32'(read_enable), 32'(0));
    chk("rst_err", 32'(tx_error), 32'(0));
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    vt[0] = '{4'h2, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 0, -1};
    vt[1] = '{4'h3, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 0, -1};
    vt[2] = '{4'hB, 1, 16'hFFFF, 16'h0000, 16'h0000, 1, 1'b0, 0, -1};
    vt[3] = '{4'h3, 3, 16'h1234, 16'hABCD, 16'h5555, 2, 1'b1, 1, -1};
    vt[4] = '{4'hB, 2, 16'h00FF, 16'hFC7E, 16'h0000, 2, 1'b0, 0, -1};
    vt[5] = '{4'hA, 1, 16'hBEEF, 16'h0000, 16'h0000, 0, 1'b0, 1, -1};
    vt[6] = '{4'h2, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1, 0, 10};
    vt[7] = '{4'h3, 1, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 0, -1};

    for (int i = 0; i < 8; i++) run_vec(i);

    wr = rd;
    push(16'h1234);
    push(16'h5678);
    @(negedge clk);
    pid            = 4'h3;
    transmit_start = 1'b1;
    @(negedge clk);
    transmit_start = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'(1));
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_lines", 32'({d_plus_out, d_minus_out}), 32'(J));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_err", 32'(tx_error), 32'(0));
    @(negedge clk);
    n_rst = 1'b1;
    run_vec(2);

    chk("re_while_empty", 32'(bad_re), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
